// File: rtl/fano_branch_gen_if.sv
// Signal bundle between the Fano decoder control/feeder side and the branch generator.
interface fano_branch_gen_if #(
    parameter int AW = 6
);
    logic          i_sym_vld;
    logic [1:0]    i_sym;
    logic          o_sym_rdy;
    logic          i_cmd_vld;
    logic [1:0]    i_cmd;
    logic          i_dec_sym;
    logic          o_cmd_rdy;
    logic          o_vld;
    logic [1:0]    o_rib_0;
    logic [1:0]    o_rib_1;
    logic [1:0]    o_cur_rib;
    logic [AW-1:0] o_depth;
    logic          o_at_origin;
    logic          o_bit_vld;
    logic          o_bit;
    logic          o_frame_done;

    modport master (
        output i_sym_vld, i_sym, i_cmd_vld, i_cmd, i_dec_sym,
        input  o_sym_rdy, o_cmd_rdy, o_vld, o_rib_0, o_rib_1, o_cur_rib,
               o_depth, o_at_origin, o_bit_vld, o_bit, o_frame_done
    );

    modport slave (
        input  i_sym_vld, i_sym, i_cmd_vld, i_cmd, i_dec_sym,
        output o_sym_rdy, o_cmd_rdy, o_vld, o_rib_0, o_rib_1, o_cur_rib,
               o_depth, o_at_origin, o_bit_vld, o_bit, o_frame_done
    );
endinterface

// File: rtl/fano_branch_gen.sv
// Branch generator for the Fano metric stage: buffers one frame of received branches,
// tracks tree depth and encoder state, and replays the decided bits at frame end.
module fano_branch_gen #(
    parameter int           K     = 7,
    parameter logic [K-1:0] G0    = 7'o171,
    parameter logic [K-1:0] G1    = 7'o133,
    parameter int           DEPTH = 64,
    parameter int           AW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    fano_branch_gen_if.slave bus
);
    localparam logic [1:0]    CMD_FWD     = 2'd0;
    localparam logic [1:0]    CMD_BACK    = 2'd1;
    localparam logic [1:0]    CMD_RESTART = 2'd2;
    localparam logic [AW-1:0] LAST        = AW'(DEPTH - 1);
    localparam logic [AW-1:0] KA          = AW'(K);

    typedef enum logic [2:0] {
        ST_LOAD, ST_FETCH, ST_EMIT, ST_PRESENT, ST_BACK_RD, ST_DUMP
    } state_t;

    state_t        r_st;
    state_t        w_st_next;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_depth;
    logic [AW-1:0] r_rptr;
    logic [K-2:0]  r_state;
    logic          r_back_zero;
    logic          r_dump_last;

    logic [1:0]    sym_mem [DEPTH];
    logic          bit_mem [DEPTH];
    logic [1:0]    r_rd_sym;
    logic          r_rd_bit;

    logic          r_vld;
    logic [1:0]    r_rib_0;
    logic [1:0]    r_rib_1;
    logic [1:0]    r_cur_rib;
    logic [AW-1:0] r_depth_out;
    logic          r_at_origin;
    logic          r_bit_vld;
    logic          r_frame_done;

    logic          w_sym_acc;
    logic          w_cmd_acc;
    logic          w_fwd_acc;
    logic [AW-1:0] w_bit_raddr;
    logic [1:0]    w_rib [2];

    assign w_sym_acc = (r_st == ST_LOAD) && bus.i_sym_vld;
    assign w_cmd_acc = (r_st == ST_PRESENT) && bus.i_cmd_vld;
    assign w_fwd_acc = w_cmd_acc && (bus.i_cmd == CMD_FWD);

    // Outside DUMP the read port serves BACK: the bit that re-enters the state at the LSB.
    assign w_bit_raddr = (r_st == ST_DUMP) ? r_rptr : (r_depth - KA);

    // Both hypotheses: encoder register {b, state} with b as the newest (MSB) bit.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rib
        logic [K-1:0] w_reg;
        assign w_reg      = {((gi == 1) ? 1'b1 : 1'b0), r_state};
        assign w_rib[gi]  = {^(w_reg & G0), ^(w_reg & G1)};
    end

    always_ff @(posedge clk) begin
        if (w_sym_acc) begin
            sym_mem[r_wptr] <= bus.i_sym;
        end
        r_rd_sym <= sym_mem[r_depth];
    end

    always_ff @(posedge clk) begin
        if (w_fwd_acc) begin
            bit_mem[r_depth] <= bus.i_dec_sym;
        end
        r_rd_bit <= bit_mem[w_bit_raddr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_st <= ST_LOAD;
        end else begin
            r_st <= w_st_next;
        end
    end

    always_comb begin
        w_st_next = r_st;
        case (r_st)
            ST_LOAD: begin
                if (w_sym_acc && (r_wptr == LAST)) begin
                    w_st_next = ST_FETCH;
                end
            end
            ST_FETCH:   w_st_next = ST_EMIT;
            ST_EMIT:    w_st_next = ST_PRESENT;
            ST_PRESENT: begin
                if (w_cmd_acc) begin
                    if (bus.i_cmd == CMD_FWD) begin
                        w_st_next = (r_depth == LAST) ? ST_DUMP : ST_FETCH;
                    end else if ((bus.i_cmd == CMD_BACK) && (r_depth != '0)) begin
                        w_st_next = ST_BACK_RD;
                    end else begin
                        w_st_next = ST_FETCH;
                    end
                end
            end
            ST_BACK_RD: w_st_next = ST_FETCH;
            ST_DUMP: begin
                if (r_dump_last) begin
                    w_st_next = ST_LOAD;
                end
            end
            default:    w_st_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr       <= '0;
            r_depth      <= '0;
            r_rptr       <= '0;
            r_state      <= '0;
            r_back_zero  <= 1'b0;
            r_dump_last  <= 1'b0;
            r_vld        <= 1'b0;
            r_rib_0      <= '0;
            r_rib_1      <= '0;
            r_cur_rib    <= '0;
            r_depth_out  <= '0;
            r_at_origin  <= 1'b0;
            r_bit_vld    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_vld        <= 1'b0;
            r_bit_vld    <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_st)
                ST_LOAD: begin
                    if (w_sym_acc) begin
                        if (r_wptr == LAST) begin
                            r_wptr  <= '0;
                            r_depth <= '0;
                            r_state <= '0;
                        end else begin
                            r_wptr <= r_wptr + AW'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    r_vld       <= 1'b1;
                    r_rib_0     <= w_rib[0];
                    r_rib_1     <= w_rib[1];
                    r_cur_rib   <= r_rd_sym;
                    r_depth_out <= r_depth;
                    r_at_origin <= (r_depth == '0);
                end
                ST_PRESENT: begin
                    if (w_cmd_acc) begin
                        case (bus.i_cmd)
                            CMD_FWD: begin
                                r_state <= {bus.i_dec_sym, r_state[K-2:1]};
                                if (r_depth == LAST) begin
                                    r_rptr      <= '0;
                                    r_dump_last <= 1'b0;
                                end else begin
                                    r_depth <= r_depth + AW'(1);
                                end
                            end
                            CMD_BACK:    r_back_zero <= (r_depth < KA);
                            CMD_RESTART: begin
                                r_depth <= '0;
                                r_state <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_BACK_RD: begin
                    // Bits older than the tree root are implicit zeros.
                    r_state <= {r_state[K-3:0], r_rd_bit & ~r_back_zero};
                    r_depth <= r_depth - AW'(1);
                end
                ST_DUMP: begin
                    if (!r_dump_last) begin
                        r_bit_vld    <= 1'b1;
                        r_frame_done <= (r_rptr == LAST);
                        if (r_rptr == LAST) begin
                            r_dump_last <= 1'b1;
                        end else begin
                            r_rptr <= r_rptr + AW'(1);
                        end
                    end else begin
                        r_dump_last <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_sym_rdy    = (r_st == ST_LOAD);
    assign bus.o_cmd_rdy    = (r_st == ST_PRESENT);
    assign bus.o_vld        = r_vld;
    assign bus.o_rib_0      = r_rib_0;
    assign bus.o_rib_1      = r_rib_1;
    assign bus.o_cur_rib    = r_cur_rib;
    assign bus.o_depth      = r_depth_out;
    assign bus.o_at_origin  = r_at_origin;
    assign bus.o_bit_vld    = r_bit_vld;
    assign bus.o_bit        = r_rd_bit & r_bit_vld;
    assign bus.o_frame_done = r_frame_done;
endmodule

// File: tb/tb_fano_branch_gen.sv
// Directed bench for fano_branch_gen; expectations come from a history-based convolutional model.
`timescale 1ns/1ps
module tb_fano_branch_gen;
    localparam int         K     = 7;
    localparam int         DEPTH = 64;
    localparam int         AW    = 6;
    localparam logic [6:0] G0    = 7'o171;
    localparam logic [6:0] G1    = 7'o133;
    localparam logic [1:0] FWD   = 2'd0;
    localparam logic [1:0] BACK  = 2'd1;
    localparam logic [1:0] RST   = 2'd2;
    localparam logic [1:0] NOP   = 2'd3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    // Model: received branches, decided-bit history per depth, current depth, dump index.
    logic [1:0] m_sym  [DEPTH];
    logic       m_hist [DEPTH];
    int         m_depth    = 0;
    int         m_dump_idx = 0;
    logic [1:0] rec0 [DEPTH];
    logic [1:0] rec1 [DEPTH];

    fano_branch_gen_if #(.AW(AW)) bus ();

    fano_branch_gen #(.K(K), .G0(G0), .G1(G1), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Encoder output as a convolution over the decided-bit history.
    function automatic logic [1:0] f_rib(input int d, input logic b);
        logic [6:0] g0v;
        logic [6:0] g1v;
        logic       u;
        logic       x0;
        logic       x1;
        g0v = G0;
        g1v = G1;
        x0  = 1'b0;
        x1  = 1'b0;
        for (int j = 0; j < K; j++) begin
            if (j == 0)          u = b;
            else if (d - j >= 0) u = m_hist[d - j];
            else                 u = 1'b0;
            x1 = x1 ^ (g0v[K-1-j] & u);
            x0 = x0 ^ (g1v[K-1-j] & u);
        end
        return {x1, x0};
    endfunction

    task automatic model_cmd(input logic [1:0] c, input logic d, output bit to_dump);
        to_dump = 1'b0;
        case (c)
            FWD: begin
                m_hist[m_depth] = d;
                if (m_depth == DEPTH - 1) begin
                    to_dump    = 1'b1;
                    m_dump_idx = 0;
                end else begin
                    m_depth++;
                end
            end
            BACK: if (m_depth > 0) m_depth--;
            RST:  m_depth = 0;
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.o_vld) begin
                chk("vld_depth",  int'(bus.o_depth),     m_depth);
                chk("vld_rib0",   int'(bus.o_rib_0),     int'(f_rib(m_depth, 1'b0)));
                chk("vld_rib1",   int'(bus.o_rib_1),     int'(f_rib(m_depth, 1'b1)));
                chk("vld_cur",    int'(bus.o_cur_rib),   int'(m_sym[m_depth]));
                chk("vld_origin", int'(bus.o_at_origin), (m_depth == 0) ? 1 : 0);
            end
            if (bus.o_bit_vld) begin
                if (m_dump_idx < DEPTH) begin
                    chk("dump_bit",  int'(bus.o_bit),        int'(m_hist[m_dump_idx]));
                    chk("dump_done", int'(bus.o_frame_done), (m_dump_idx == DEPTH - 1) ? 1 : 0);
                    m_dump_idx++;
                end else begin
                    chk("dump_extra", int'(bus.o_bit_vld), 0);
                end
            end
        end
    end

    task automatic wait_vld(input string name, input bit exact);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.o_vld && n < 20);
        if (!bus.o_vld)  chk({name, "_timeout"}, int'(bus.o_vld), 1);
        else if (exact)  chk(name, n, 2);
    endtask

    task automatic do_reset(input string tag);
        bus.i_sym_vld = 1'b0;
        bus.i_cmd_vld = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_outs_zero"}, int'({bus.o_vld, bus.o_rib_0, bus.o_rib_1, bus.o_cur_rib,
            bus.o_depth, bus.o_at_origin, bus.o_bit_vld, bus.o_bit, bus.o_frame_done,
            bus.o_cmd_rdy}), 0);
        chk({tag, "_sym_rdy"}, int'(bus.o_sym_rdy), 1);
        reset = 1'b0;
        $display("reset %s at cycle %0d", tag, cyc);
    endtask

    task automatic load_frame(input int mode);
        logic [1:0] s;
        int         n;
        for (int i = 0; i < DEPTH; i++) begin
            s = (mode == 0) ? 2'b00 : 2'(i);
            n = 0;
            while (!bus.o_sym_rdy && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (!bus.o_sym_rdy) chk("sym_rdy_timeout", int'(bus.o_sym_rdy), 1);
            bus.i_sym_vld = 1'b1;
            bus.i_sym     = s;
            @(posedge clk); #1;
            m_sym[i] = s;
        end
        bus.i_sym_vld = 1'b0;
        m_depth = 0;
        $display("frame load mode %0d: %0d branches", mode, DEPTH);
        wait_vld("load_lat", 1'b1);
    endtask

    task automatic send_cmd(input logic [1:0] c, input logic d);
        int n;
        bit moves_back;
        bit to_dump;
        n = 0;
        while (!bus.o_cmd_rdy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.o_cmd_rdy) chk("cmd_rdy_timeout", int'(bus.o_cmd_rdy), 1);
        bus.i_cmd_vld = 1'b1;
        bus.i_cmd     = c;
        bus.i_dec_sym = d;
        @(posedge clk); #1;
        bus.i_cmd_vld = 1'b0;
        moves_back = (c == BACK) && (m_depth != 0);
        model_cmd(c, d, to_dump);
        $display("cmd %0d bit %0d -> depth %0d", c, d, m_depth);
        if (!to_dump) wait_vld("cmd_lat", !moves_back);
    endtask

    initial begin
        logic pat [8];
        bit   dmp;
        int   first;
        int   nb;
        bit   done_seen;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < DEPTH; i++) begin
            m_hist[i] = 1'b0;
            m_sym[i]  = 2'b00;
        end
        bus.i_sym_vld = 1'b0;
        bus.i_sym     = 2'b00;
        bus.i_cmd_vld = 1'b0;
        bus.i_cmd     = 2'b00;
        bus.i_dec_sym = 1'b0;
        do_reset("init");

        // All-zero frame: root presentation.
        load_frame(0);
        chk("t1_depth", int'(bus.o_depth), 0);
        chk("t1_rib0", int'(bus.o_rib_0), 0);
        chk("t1_rib1", int'(bus.o_rib_1), 3);
        chk("t1_cur", int'(bus.o_cur_rib), 0);
        chk("t1_origin", int'(bus.o_at_origin), 1);

        send_cmd(FWD, 1'b1);
        chk("t2_depth", int'(bus.o_depth), 1);
        chk("t2_rib0", int'(bus.o_rib_0), 2);
        chk("t2_rib1", int'(bus.o_rib_1), 1);

        // Forward 8 steps, then walk back to the root.
        send_cmd(RST, 1'b0);
        rec0[0] = f_rib(0, 1'b0);
        rec1[0] = f_rib(0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            send_cmd(FWD, pat[k]);
            rec0[m_depth] = f_rib(m_depth, 1'b0);
            rec1[m_depth] = f_rib(m_depth, 1'b1);
        end
        chk("t3_depth8", int'(bus.o_depth), 8);
        for (int k = 0; k < 8; k++) begin
            send_cmd(BACK, 1'b0);
            chk("t3_back_depth", int'(bus.o_depth), 7 - k);
            chk("t3_back_rib0", int'(bus.o_rib_0), int'(rec0[7 - k]));
            chk("t3_back_rib1", int'(bus.o_rib_1), int'(rec1[7 - k]));
        end
        send_cmd(BACK, 1'b0);
        chk("t3_root_depth", int'(bus.o_depth), 0);
        chk("t3_root_rib0", int'(bus.o_rib_0), 0);
        chk("t3_root_rib1", int'(bus.o_rib_1), 3);

        // Commands held high: only PRESENT cycles accept; symbols are dropped.
        bus.i_sym_vld = 1'b1;
        bus.i_sym     = 2'b11;
        bus.i_cmd_vld = 1'b1;
        bus.i_cmd     = FWD;
        bus.i_dec_sym = 1'b1;
        for (int k = 0; k < 13; k++) begin
            chk("t6_fwd_cmd_rdy", int'(bus.o_cmd_rdy), (k % 3 == 0) ? 1 : 0);
            chk("t6_sym_rdy", int'(bus.o_sym_rdy), 0);
            @(posedge clk); #1;
            if (k % 3 == 0) begin
                model_cmd(FWD, 1'b1, dmp);
                $display("held FWD accepted -> depth %0d", m_depth);
            end
        end
        bus.i_cmd_vld = 1'b0;
        wait_vld("t6_fwd_lat", 1'b1);
        chk("t6_fwd_depth", int'(bus.o_depth), 5);
        bus.i_cmd_vld = 1'b1;
        bus.i_cmd     = BACK;
        for (int k = 0; k < 9; k++) begin
            chk("t6_back_cmd_rdy", int'(bus.o_cmd_rdy), (k % 4 == 0) ? 1 : 0);
            @(posedge clk); #1;
            if (k % 4 == 0) begin
                model_cmd(BACK, 1'b0, dmp);
                $display("held BACK accepted -> depth %0d", m_depth);
            end
        end
        bus.i_cmd_vld = 1'b0;
        bus.i_sym_vld = 1'b0;
        wait_vld("t6_back_wait", 1'b0);
        chk("t6_back_depth", int'(bus.o_depth), 2);
        send_cmd(NOP, 1'b0);
        chk("t6_nop_depth", int'(bus.o_depth), 2);
        send_cmd(RST, 1'b0);
        chk("t6_cur_kept", int'(bus.o_cur_rib), 0);

        // Reset mid-frame at depth 20.
        for (int k = 0; k < 20; k++) send_cmd(FWD, (k % 3 == 0) ? 1'b1 : 1'b0);
        chk("t5_depth20", int'(bus.o_depth), 20);
        do_reset("mid");

        // Counting frame: fresh load starts at root with zero state.
        load_frame(1);
        chk("t5_new_depth", int'(bus.o_depth), 0);
        chk("t5_new_rib0", int'(bus.o_rib_0), 0);
        chk("t5_new_rib1", int'(bus.o_rib_1), 3);
        for (int i = 0; i < DEPTH; i++) begin
            send_cmd(FWD, i[0]);
            if (i < DEPTH - 1) chk("t4_cur_rib", int'(bus.o_cur_rib), (i + 1) % 4);
        end
        first     = -1;
        nb        = 0;
        done_seen = 1'b0;
        for (int n = 0; n < 200 && !done_seen; n++) begin
            @(posedge clk); #1;
            if (bus.o_bit_vld) begin
                if (first < 0) first = cyc;
                chk("t4_bit", int'(bus.o_bit), nb % 2);
                nb++;
            end
            if (bus.o_frame_done) begin
                done_seen = 1'b1;
                chk("t4_nbits", nb, 64);
                chk("t4_span", cyc - first, 63);
            end
        end
        if (!done_seen) chk("t4_done_timeout", int'(bus.o_frame_done), 1);
        $display("frame dump: %0d bits", nb);
        @(posedge clk); #1;
        chk("t4_sym_rdy_after", int'(bus.o_sym_rdy), 1);
        chk("t4_bit_vld_after", int'(bus.o_bit_vld), 0);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
